// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted op, with
// byte-lane steering, load extension, pipeline stall and error reporting.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Valid, MemRead, MemWrite, Funct3, Addr, WrData
//                       memory op from execute (accepted only when idle)
//   MemReq, MemWe, MemAddr, MemWData, MemBE
//                       request side of the data-memory handshake
//   MemRData, MemReady  response side of the data-memory handshake
//   RdData, Done, Busy, Error, Misaligned
//                       result, completion pulse, stall and status flags
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned
// halfword/word accesses instead of silently ignoring the low address bits.

module lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic                  MemReq,
    output logic                  MemWe,
    output logic [DATA_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic [3:0]            MemBE,
    input  logic [DATA_WIDTH-1:0] MemRData,
    input  logic                  MemReady,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  Done,
    output logic                  Busy,
    output logic                  Error,
    output logic                  Misaligned
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            f3_q, f3_d;
    logic                  we_q, we_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  mis_q, mis_d;

    // Incoming op decode
    logic f3_ok;
    logic illegal;
    logic mis_trap;

    always_comb begin
        f3_ok = 1'b0;
        if (MemWrite) begin
            f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                    (Funct3 == 3'b010);
        end else begin
            f3_ok = (Funct3 == 3'b000) || (Funct3 == 3'b001) ||
                    (Funct3 == 3'b010) || (Funct3 == 3'b100) ||
                    (Funct3 == 3'b101);
        end
    end

    assign illegal = (MemRead && MemWrite) || !f3_ok;

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_trap = !illegal &&
                      (((Funct3[1:0] == 2'b01) && Addr[0]) ||
                       ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00)));
`else
    assign mis_trap = 1'b0;
`endif

    // Lane steering from the captured op
    logic [3:0]            be_c;
    logic [DATA_WIDTH-1:0] wd_c;
    logic [DATA_WIDTH-1:0] ld_c;
    logic [DATA_WIDTH-1:0] sh_b;
    logic [DATA_WIDTH-1:0] sh_h;

    assign sh_b = MemRData >> {addr_q[1:0], 3'b000};
    assign sh_h = MemRData >> {addr_q[1], 4'b0000};

    always_comb begin
        be_c = 4'b1111;
        wd_c = wdata_q;
        ld_c = MemRData;
        unique case (f3_q[1:0])
            2'b00: begin
                be_c = 4'b0001 << addr_q[1:0];
                wd_c = {NB{wdata_q[7:0]}};
                ld_c = {{(DATA_WIDTH-8){sh_b[7] & ~f3_q[2]}},
                        sh_b[7:0]};
            end
            2'b01: begin
                // Halfword lane comes from Addr[1] only; Addr[0] is
                // either trapped at accept or ignored.
                be_c = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_c = {(NB/2){wdata_q[15:0]}};
                ld_c = {{(DATA_WIDTH-16){sh_h[15] & ~f3_q[2]}},
                        sh_h[15:0]};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = wdata_q;
                ld_c = MemRData;
            end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mis_d   = mis_q;
        unique case (state_q)
            IDLE: begin
                if (Valid && (MemRead || MemWrite)) begin
                    addr_d  = Addr;
                    wdata_d = WrData;
                    f3_d    = Funct3;
                    we_d    = MemWrite;
                    cnt_d   = '0;
                    if (illegal || mis_trap) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        mis_d   = mis_trap;
                        rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (MemReady) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    mis_d   = 1'b0;
                    rdata_d = we_q ? '0 : ld_c;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    mis_d   = 1'b0;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    // Outputs
    logic acc;
    assign acc = (state_q == ACCESS);

    assign MemReq     = acc;
    assign MemWe      = acc && we_q;
    assign MemAddr    = acc ? {addr_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign MemWData   = acc ? wd_c : '0;
    assign MemBE      = acc ? be_c : 4'b0000;
    assign RdData     = rdata_q;
    assign Done       = (state_q == RESP);
    assign Busy       = (state_q != IDLE);
    assign Error      = err_q;
    assign Misaligned = mis_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: random ops against a byte-lane reference
// model, a memory responder, and a Done monitor.

module tb_lsu;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        Valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, WrData;
    logic        MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBE;
    logic [31:0] MemRData;
    logic        MemReady;
    logic [31:0] RdData;
    logic        Done, Busy, Error, Misaligned;

    lsu #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .Valid(Valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .Funct3(Funct3), .Addr(Addr),
        .WrData(WrData), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE),
        .MemRData(MemRData), .MemReady(MemReady), .RdData(RdData),
        .Done(Done), .Busy(Busy), .Error(Error),
        .Misaligned(Misaligned)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          done_cyc;
        bit          err;
        bit          mis;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          lat;
        int          nreq;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        bit          we;
        logic [31:0] rdata;
    } mem_t;

    exp_t sbq[$];
    mem_t memq[$];
    int   cmp = 0;
    int   bad = 0;
    bit   abort = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Drive random junk while the unit is busy; it must be ignored.
    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 100) begin
            Valid    = 1'($urandom);
            MemRead  = 1'($urandom);
            MemWrite = 1'($urandom);
            Funct3   = 3'($urandom);
            Addr     = $urandom;
            WrData   = $urandom;
            @(negedge clk);
            n++;
        end
        if (Busy) chk("busy_timeout", 32'(Busy), 0);
        Valid = 1'b0;
    endtask

    // Present one op and push the model's expected response.
    task automatic issue(bit rd, bit wr, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] wd,
                         int lat, logic [31:0] rdat);
        bit          legal, mis;
        int          sz, off, T;
        logic [31:0] be, mask, v, rep;
        exp_t        e;
        mem_t        m;
        wait_idle();
        Valid = 1'b1; MemRead = rd; MemWrite = wr;
        Funct3 = f3; Addr = a; WrData = wd;
        T = cyc;
        if (!rd && !wr) begin
            @(negedge clk);
            chk("ignored_busy", 32'(Busy), 0);
            Valid = 1'b0;
            return;
        end
        if (wr && !rd)
            legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
        else
            legal = !wr && ((f3 == 0) || (f3 == 1) || (f3 == 2) ||
                            (f3 == 4) || (f3 == 5));
        sz = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        mis = legal && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 0));
`else
        mis = 0;
`endif
        if (!legal || mis) begin
            e = '{T + 1, 1'b1, mis, 1'b0, 32'h0};
            sbq.push_back(e);
        end else begin
            off  = (sz == 1) ? (a % 4) : (sz == 2) ? ((a % 4) / 2) * 2 : 0;
            be   = ((32'h1 << sz) - 1) << off;
            mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
            v    = (rdat >> (8 * off)) & mask;
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
            if (sz == 1) rep = {24'h0, wd[7:0]} * 32'h0101_0101;
            else if (sz == 2) rep = {16'h0, wd[15:0]} * 32'h0001_0001;
            else rep = wd;
            if (lat <= TO)
                e = '{T + lat + 1, 1'b0, 1'b0, 1'b1, wr ? 32'h0 : v};
            else
                e = '{T + TO + 1, 1'b1, 1'b0, 1'b1, 32'h0};
            sbq.push_back(e);
            m = '{lat, (lat <= TO) ? lat : TO, a & ~32'h3,
                  be[3:0], rep, wr, rdat};
            memq.push_back(m);
        end
        @(negedge clk);
        Valid = 1'b0;
    endtask

    // Memory responder: checks request fields every request cycle.
    initial begin
        int   j = 0;
        bit   have = 0;
        mem_t m;
        MemReady = 1'b0;
        MemRData = '0;
        forever begin
            @(negedge clk);
            if (MemReq) begin
                if (!have) begin
                    if (memq.size() == 0) begin
                        chk("unexpected_req", 1, 0);
                    end else begin
                        m = memq.pop_front();
                        have = 1;
                        j = 0;
                    end
                end
                if (have) begin
                    j++;
                    chk("mem_addr", MemAddr, m.addr);
                    chk("mem_we", 32'(MemWe), 32'(m.we));
                    if (m.we) begin
                        chk("mem_be", 32'(MemBE), 32'(m.be));
                        chk("mem_wdata", MemWData, m.wd);
                    end
                    MemReady = (j == m.lat);
                    MemRData = (j == m.lat) ? m.rdata : $urandom;
                end
            end else begin
                if (have) begin
                    if (abort) abort = 0;
                    else chk("req_cycles", j, m.nreq);
                    have = 0;
                end
                MemReady = 1'($urandom);
                MemRData = $urandom;
            end
        end
    end

    // Done monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && Done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("error", 32'(Error), 32'(e.err));
                    chk("misaligned", 32'(Misaligned), 32'(e.mis));
                    if (e.chk_rd) chk("rddata", RdData, e.rd);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        Funct3 = '0; Addr = '0; WrData = '0;
        repeat (3) @(negedge clk);
        chk("rst_memreq", 32'(MemReq), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_error", 32'(Error), 0);
        chk("rst_rddata", RdData, 0);
        chk("rst_membe", 32'(MemBE), 0);
        reset = 1'b0;

        issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 3, 0);
        issue(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF_FF7F);
        issue(1, 0, 3'b100, 32'h103, 0, 1, 32'h80FF_FF7F);
        issue(0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 2, 0);
        issue(1, 0, 3'b010, 32'h200, 0, TO + 5, 32'h1234_5678);
        issue(1, 0, 3'b010, 32'h101, 0, 2, 32'h1234_5678);
        issue(1, 0, 3'b001, 32'h303, 0, 1, 32'h8001_7FFE);
        issue(1, 1, 3'b010, 32'h10, 0, 1, 0);
        issue(0, 1, 3'b100, 32'h10, 0, 1, 0);
        issue(1, 0, 3'b011, 32'h10, 0, 1, 0);
        issue(1, 0, 3'b111, 32'h10, 0, 1, 0);
        issue(0, 0, 3'b010, 32'h10, 0, 1, 0);
        issue(1, 0, 3'b010, 32'h40, 0, TO, 32'hCAFE_F00D);

        for (int i = 0; i < 300; i++) begin
            bit rd, wr;
            int r = $urandom_range(0, 15);
            rd = (r < 8) || (r == 15);
            wr = (r >= 7);
            issue(rd, wr, 3'($urandom), $urandom, $urandom,
                  $urandom_range(1, TO + 3), $urandom);
        end

        // Reset in the middle of a stalled load
        issue(1, 0, 3'b010, 32'h500, 0, 1000, 0);
        @(negedge clk);
        abort = 1;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_memreq", 32'(MemReq), 0);
        chk("midrst_busy", 32'(Busy), 0);
        chk("midrst_done", 32'(Done), 0);
        reset = 1'b0;
        void'(sbq.pop_back());
        issue(1, 0, 3'b101, 32'h602, 0, 2, 32'h9ABC_0000);

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_sb", sbq.size(), 0);
        chk("drain_mem", memq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the ALU in the execute/memory path. It takes the ALU's computed effective address plus the store data and memory-op controls, runs one data-memory transaction over a ready-based handshake, and returns a sign- or zero-extended load result. It stalls the pipeline while a transaction is outstanding and flags illegal or timed-out accesses.

## Interface
- DATA_WIDTH, 32, address/data width (fixed byte lanes: 4)
- TIMEOUT_CYCLES, 16, max cycles waiting for MemReady before abort (>=1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- Valid  in  1  memory op presented this cycle
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- Addr  in  DATA_WIDTH  effective address (ALUResult)
- WrData  in  DATA_WIDTH  store data (rs2)
- MemReq  out  1  transaction request to data memory
- MemWe  out  1  1 = write
- MemAddr  out  DATA_WIDTH  Addr with bits [1:0] forced to 0
- MemWData  out  DATA_WIDTH  lane-replicated store data
- MemBE  out  4  byte enables
- MemRData  in  DATA_WIDTH  read word from memory
- MemReady  in  1  memory completes the current transaction
- RdData  out  DATA_WIDTH  extended load result
- Done  out  1  one-cycle completion pulse
- Busy  out  1  transaction outstanding (pipeline stall)
- Error  out  1  qualifies Done: access failed
- Misaligned  out  1  qualifies Done: misaligned access (macro only)

## Operation
- States: IDLE, ACCESS, RESP. Reset -> IDLE, all outputs 0.
- IDLE: Valid=1 with exactly one of MemRead/MemWrite accepted; both set, unsupported Funct3 (011, 110, 111; any 1xx on a store) -> RESP with Error=1, no MemReq. Neither set -> ignored.
- Accept captures Addr, WrData, Funct3, direction; legal op -> ACCESS.
- ACCESS: MemReq=1, MemWe/MemAddr/MemWData/MemBE held stable. MemReady=1 -> capture MemRData, -> RESP. Timeout counter reaching TIMEOUT_CYCLES -> RESP with Error=1, RdData=0.
- RESP: Done=1 for exactly one cycle, -> IDLE.
- Busy=1 in ACCESS and RESP; Valid while Busy=1 is ignored (upstream holds the op).
- Store lanes: SB MemBE=0001<<Addr[1:0], data {4{WrData[7:0]}}; SH MemBE=0011<<(2*Addr[1]), data {2{WrData[15:0]}}; SW MemBE=1111.
- Load: select byte by Addr[1:0], halfword by Addr[1]; B/H sign-extend, BU/HU zero-extend, W passthrough. Stores return RdData=0.
- MemReady outside ACCESS ignored.

## Timing
- Accept at cycle T -> MemReq high from T+1.
- MemReady sampled high at T+k (k>=1) -> MemReq low, Done and RdData at T+k+1. Minimum accept-to-Done: 2 cycles.
- Illegal op: Done+Error at T+1, MemReq never asserted.
- Timeout: MemReq high T+1..T+TIMEOUT_CYCLES, Done+Error at T+TIMEOUT_CYCLES+1.
- Next op accepted no earlier than the Done cycle + 1 (IDLE).
- RdData/Error/Misaligned hold until next Done; Done is registered.
- reset mid-transaction: IDLE next cycle, MemReq=0, no Done pulse; counter cleared.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: H with Addr[0]=1 or W with Addr[1:0]!=0 -> no MemReq, Done at T+1 with Error=1, Misaligned=1.
- Undefined: offending low bits ignored (H uses Addr[1] only, W uses offset 0), access proceeds normally; Misaligned tied 0.

## Test plan
- SW Addr=0x100, WrData=0xDEADBEEF, MemReady after 3 cycles -> MemAddr=0x100, MemBE=1111, MemReq high 3 cycles, Done at T+4, Error=0.
- LB Addr=0x103, MemRData=0x80FF_FF7F, MemReady at T+1 -> RdData=0xFFFFFF80 at T+2; repeat as LBU -> 0x00000080.
- SH Addr=0x202, WrData=0x0000ABCD -> MemBE=1100, MemWData=0xABCDABCD.
- LW with MemReady never asserted, TIMEOUT_CYCLES=16 -> MemReq drops, Done+Error at T+17, RdData=0.
- LW Addr=0x101: with macro -> Done+Error+Misaligned at T+1, no MemReq; without -> MemAddr=0x100, normal load.
- reset asserted at T+2 of a stalled load -> IDLE at T+3, MemReq=0, Busy=0, no Done; next Valid accepted.
